// File: rtl/enigma_pkg.sv
// Shared constants, rotor tables and helpers for the Enigma rotor core.
// Rotor wirings are stored as letter indices: out = WIRING[in].
package enigma_pkg;

  localparam int ALPHA = 26;

  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;

  typedef logic [ALPHA-1:0] oh_t;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    FWD,
    CAP,
    REV,
    DONE
  } state_t;

  localparam int WIRING_I [ALPHA] = '{
    4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14,
    22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9
  };
  localparam int WIRING_II [ALPHA] = '{
    0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22,
    19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4
  };
  localparam int WIRING_III [ALPHA] = '{
    1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25,
    13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14
  };

  localparam int INV_I [ALPHA] = '{
    20, 22, 24, 6, 0, 3, 5, 15, 21, 25, 1, 4, 2,
    10, 12, 19, 7, 23, 18, 11, 17, 8, 13, 16, 14, 9
  };
  localparam int INV_II [ALPHA] = '{
    0, 9, 15, 2, 25, 22, 17, 11, 5, 1, 3, 10, 14,
    19, 24, 20, 16, 6, 4, 13, 7, 23, 12, 8, 21, 18
  };
  localparam int INV_III [ALPHA] = '{
    19, 0, 6, 1, 15, 2, 18, 3, 16, 4, 20, 5, 21,
    13, 25, 7, 24, 8, 23, 9, 22, 11, 17, 10, 14, 12
  };

  function automatic int wire_idx(int rotor, bit inv, int j);
    case (rotor)
      1:       return inv ? INV_I[j]   : WIRING_I[j];
      2:       return inv ? INV_II[j]  : WIRING_II[j];
      default: return inv ? INV_III[j] : WIRING_III[j];
    endcase
  endfunction

  function automatic oh_t rotl(oh_t x, int p);
    logic [2*ALPHA-1:0] t;
    t = {x, x} << p;
    return t[2*ALPHA-1:ALPHA];
  endfunction

  function automatic oh_t rotr(oh_t x, int p);
    logic [2*ALPHA-1:0] t;
    t = {x, x} >> p;
    return t[ALPHA-1:0];
  endfunction

  function automatic logic is_onehot(oh_t x);
    return (x != '0) && ((x & (x - oh_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/rotor_reflector_driver_if.sv
// Keyboard-side and lamp-side valid/ready handshakes of the rotor core.
// master: keyboard/lamp consumer; slave: the rotor core.
interface rotor_reflector_driver_if;
  import enigma_pkg::*;

  oh_t  key;
  logic key_valid;
  logic key_ready;
  oh_t  lamp;
  logic lamp_valid;
  logic lamp_ready;

  modport master (
    output key, key_valid, lamp_ready,
    input  key_ready, lamp, lamp_valid
  );

  modport slave (
    input  key, key_valid, lamp_ready,
    output key_ready, lamp, lamp_valid
  );

endinterface

// File: rtl/rotor_map.sv
// One-hot letter map through a single rotor at position pos.
// inv selects the reverse (reflector-to-keyboard) direction.
module rotor_map
  import enigma_pkg::*;
#(
  parameter int ROTOR = 1,
  parameter int POS_W = 5
) (
  input  oh_t              d,
  input  logic [POS_W-1:0] pos,
  input  logic             inv,
  output oh_t              out
);

  oh_t rot;
  oh_t fperm;
  oh_t iperm;

  assign rot = rotl(d, int'(pos));

  for (genvar j = 0; j < ALPHA; j++) begin : g_wire
    localparam int FI = wire_idx(ROTOR, 1'b0, j);
    localparam int II = wire_idx(ROTOR, 1'b1, j);
    assign fperm[FI] = rot[j];
    assign iperm[II] = rot[j];
  end

  assign out = rotr(inv ? iperm : fperm, int'(pos));

endmodule

// File: rtl/rotor_reflector_driver.sv
// Sequential Enigma core: steps rotors I/II/III, drives the external
// reflector, and returns the reflected letter through the inverse path.
module rotor_reflector_driver
  import enigma_pkg::*;
#(
  parameter int REFL_WAIT = 1,
  parameter int POS_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rotor_reflector_driver_if.slave kb,
  input  logic                   pos_load,
  input  logic [3*POS_W-1:0]     pos_in,
  output logic [3*POS_W-1:0]     pos_out,
  output oh_t                    refl_d,
  input  oh_t                    refl_out,
  output logic                   err
);

  localparam int CW = (REFL_WAIT > 1) ? $clog2(REFL_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFL_WAIT - 1);
  localparam logic [POS_W-1:0] PMAX = POS_W'(ALPHA - 1);
  localparam logic [POS_W-1:0] N2 = POS_W'(NOTCH_II);
  localparam logic [POS_W-1:0] N3 = POS_W'(NOTCH_III);

  state_t state, state_nx;

  logic [POS_W-1:0] pl, pm, pr;
  logic [POS_W-1:0] in_l, in_m, in_r;
  logic [CW-1:0]    cnt;
  oh_t  key_q, cap_q, lamp_q;
  logic cap_bad;
  logic err_nx, accept, load, fields_ok, fwd_last;
  oh_t  f_r, f_m, f_l, r_l, r_m, r_r;

  function automatic logic [POS_W-1:0] inc(logic [POS_W-1:0] p);
    return (p == PMAX) ? '0 : p + POS_W'(1);
  endfunction

  assign {in_l, in_m, in_r} = pos_in;
  assign fields_ok = (in_l <= PMAX) && (in_m <= PMAX) && (in_r <= PMAX);
  assign fwd_last  = (cnt == LAST);

  rotor_map #(.ROTOR(3), .POS_W(POS_W)) u_fr (
    .d(key_q), .pos(pr), .inv(1'b0), .out(f_r));
  rotor_map #(.ROTOR(2), .POS_W(POS_W)) u_fm (
    .d(f_r), .pos(pm), .inv(1'b0), .out(f_m));
  rotor_map #(.ROTOR(1), .POS_W(POS_W)) u_fl (
    .d(f_m), .pos(pl), .inv(1'b0), .out(f_l));
  rotor_map #(.ROTOR(1), .POS_W(POS_W)) u_il (
    .d(cap_q), .pos(pl), .inv(1'b1), .out(r_l));
  rotor_map #(.ROTOR(2), .POS_W(POS_W)) u_im (
    .d(r_l), .pos(pm), .inv(1'b1), .out(r_m));
  rotor_map #(.ROTOR(3), .POS_W(POS_W)) u_ir (
    .d(r_m), .pos(pr), .inv(1'b1), .out(r_r));

  assign kb.key_ready  = (state == IDLE) && !pos_load;
  assign kb.lamp_valid = (state == DONE);
  assign kb.lamp       = lamp_q;
  assign refl_d        = (state == FWD) ? f_l : '0;
  assign pos_out       = {pl, pm, pr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        // a load request shadows any key offered in the same cycle
        if (pos_load) begin
          load   = fields_ok;
          err_nx = !fields_ok;
        end else if (kb.key_valid) begin
          accept   = is_onehot(kb.key);
          err_nx   = !accept;
          state_nx = accept ? STEP : IDLE;
        end
      end
      STEP: state_nx = FWD;
      FWD: begin
        if (fwd_last) begin
          state_nx = CAP;
          err_nx   = !is_onehot(refl_out);
        end
      end
      CAP:  state_nx = REV;
      REV:  state_nx = DONE;
      DONE: if (kb.lamp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl      <= '0;
      pm      <= '0;
      pr      <= '0;
      cnt     <= '0;
      key_q   <= '0;
      cap_q   <= '0;
      cap_bad <= 1'b0;
      lamp_q  <= '0;
      err     <= 1'b0;
    end else begin
      err <= err_nx;
      if (load) {pl, pm, pr} <= pos_in;
      if (accept) key_q <= kb.key;
      // middle double-steps on its own notch, carrying the left rotor
      if (state == STEP) begin
        pr <= inc(pr);
        if (pr == N3 || pm == N2) pm <= inc(pm);
        if (pm == N2) pl <= inc(pl);
      end
      if (state == FWD) begin
        cnt <= fwd_last ? '0 : cnt + CW'(1);
        if (fwd_last) begin
          cap_q   <= refl_out;
          cap_bad <= !is_onehot(refl_out);
        end
      end
      if (state == REV) lamp_q <= cap_bad ? '0 : r_r;
      if (state == DONE && kb.lamp_ready) lamp_q <= '0;
    end
  end

endmodule
